// File: rtl/pkt_tx_drain.sv
// Egress reader for the shared packet buffer: issues reads at the head pointer, classifies
// returned words, and forwards whole packets through a 2-entry skid to the output queue.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// WAIT_SOP | between packets; only an SOP word starts a packet
// FWD      | forwarding the current packet into the skid until its EOP
// DROP     | discarding the current packet until its EOP
module pkt_tx_drain #(
  parameter int DWIDTH = 72,
  parameter int PTR_W  = 8
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              en_i,
  input  logic [PTR_W-1:0]  tail_addr_i,
  input  logic              stop_tx_i,
  input  logic              drop_packet_i,
  output logic [PTR_W-1:0]  head_addr_o,
  output logic [PTR_W-1:0]  rd_addr_o,
  output logic              rd_en_o,
  input  logic [DWIDTH-1:0] rd_data_i,
  output logic [63:0]       out_data_o,
  output logic [7:0]        out_ctrl_o,
  output logic              out_wr_o,
  input  logic              out_rdy_i,
  output logic              pkt_sent_o,
  output logic              pkt_dropped_o,
  output logic              proto_err_o
);

  typedef enum logic [1:0] {
    WAIT_SOP = 2'd0,
    FWD      = 2'd1,
    DROP     = 2'd2
  } state_t;

  localparam int EW = 73;  // {eop flag, ctrl, data}

  state_t           state_q;
  logic             drop_req_q;
  logic             prev_zero_q;
  logic             pkt_sent_q;
  logic             pkt_dropped_q;
  logic             proto_err_q;

  logic [PTR_W-1:0] head_q, head_d;
  logic             run_q;
  logic             inflight_q;
  logic [1:0]       occ_q, occ_d;
  logic [EW-1:0]    ent0_q, ent0_d;
  logic [EW-1:0]    ent1_q, ent1_d;

  logic             empty;
  logic             out_wr;
  logic [2:0]       credit_sum;
  logic             credit;
  logic             rd_en;
  logic [7:0]       ret_ctrl;
  logic [63:0]      ret_data;
  logic             is_sop;
  logic             is_eop;
  logic             push;
  logic             push_eop;
  logic             drop_clr;
  logic [EW-1:0]    push_word;

  assign empty      = (head_q == tail_addr_i);
  assign out_wr     = (occ_q != 2'd0) & out_rdy_i;
  // In-flight words are counted against the skid even if they end up discarded.
  assign credit_sum = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, out_wr};
  assign credit     = (credit_sum < 3'd2);
  assign rd_en      = run_q & en_i & ~stop_tx_i & ~empty & credit;

  assign ret_ctrl = rd_data_i[DWIDTH-1 -: 8];
  assign ret_data = rd_data_i[63:0];
  assign is_sop   = (ret_ctrl == 8'hFF);
  assign is_eop   = (ret_ctrl != 8'h00) & prev_zero_q;

  assign push      = inflight_q &
                     ((state_q == FWD) | ((state_q == WAIT_SOP) & is_sop & ~drop_req_q));
  assign push_eop  = (state_q == FWD) & is_eop;
  assign push_word = {push_eop, ret_ctrl, ret_data};
  assign drop_clr  = inflight_q & (state_q == DROP) & is_eop;

  assign head_d = rd_en ? head_q + PTR_W'(1) : head_q;

  always_comb begin
    occ_d  = occ_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    case ({push, out_wr})
      2'b01: begin
        occ_d  = occ_q - 2'd1;
        ent0_d = ent1_q;
      end
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) ent0_d = push_word;
        else               ent1_d = push_word;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          ent0_d = push_word;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_word;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_q     <= '0;
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      ent0_q     <= '0;
      ent1_q     <= '0;
    end else begin
      head_q     <= head_d;
      run_q      <= 1'b1;
      inflight_q <= rd_en;
      occ_q      <= occ_d;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= WAIT_SOP;
      drop_req_q    <= 1'b0;
      prev_zero_q   <= 1'b0;
      pkt_sent_q    <= 1'b0;
      pkt_dropped_q <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      pkt_sent_q    <= out_wr & ent0_q[EW-1];
      pkt_dropped_q <= 1'b0;
      proto_err_q   <= 1'b0;
      drop_req_q    <= drop_packet_i | (drop_req_q & ~drop_clr);
      if (inflight_q) begin
        prev_zero_q <= (ret_ctrl == 8'h00);
        case (state_q)
          WAIT_SOP: begin
            if (is_sop) state_q <= drop_req_q ? DROP : FWD;
            else        proto_err_q <= 1'b1;
          end
          FWD: begin
            if (is_eop) state_q <= WAIT_SOP;
          end
          DROP: begin
            if (is_eop) begin
              state_q       <= WAIT_SOP;
              pkt_dropped_q <= 1'b1;
            end
          end
          default: state_q <= WAIT_SOP;
        endcase
      end
    end
  end

  assign head_addr_o   = head_q;
  assign rd_addr_o     = head_q;
  assign rd_en_o       = rd_en;
  assign out_wr_o      = out_wr;
  assign out_ctrl_o    = ent0_q[71:64];
  assign out_data_o    = ent0_q[63:0];
  assign pkt_sent_o    = pkt_sent_q;
  assign pkt_dropped_o = pkt_dropped_q;
  assign proto_err_o   = proto_err_q;

endmodule
